mux_scan_sequencer: RTL

MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

---
 rtl/mux_scan_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mux_scan_sequencer.sv
// Sequencer for a downstream 4:1 mux: walks the enabled channels in ascending order,
// holds each select for DWELL cycles, then captures the mux output for that channel.
module mux_scan_sequencer #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] ch_mask,
    input  logic       y,
    output logic       sel1,
    output logic       sel2,
    output logic       busy,
    output logic       done,
    output logic       sample_valid,
    output logic [1:0] sample_ch,
    output logic       sample_data,
    output logic [3:0] scan_result
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DWELL  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(DWELL - 1);

    // Lowest enabled channel at or above 'from'; result is {found, index}.
    function automatic logic [2:0] find_ch(input logic [3:0] mask, input logic [2:0] from);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if ((i >= int'(from)) && mask[i]) begin
                res = {1'b1, 2'(i)};
            end
        end
        return res;
    endfunction

    state_t     state_r, state_n;
    logic [3:0] mask_r, mask_n;
    logic [1:0] ch_r, ch_n;
    logic [3:0] cnt_r, cnt_n;
    logic       busy_r, busy_n;
    logic       done_r, done_n;
    logic       sample_valid_r, sample_valid_n;
    logic [1:0] sample_ch_r, sample_ch_n;
    logic       sample_data_r, sample_data_n;
    logic [3:0] scan_result_r, scan_result_n;
    logic [2:0] first_s;
    logic [2:0] next_s;

    assign first_s = find_ch(ch_mask, 3'd0);
    assign next_s  = find_ch(mask_r, {1'b0, ch_r} + 3'd1);

    // Next-state and next-output logic for the scan FSM.
    always_comb begin
        state_n        = state_r;
        mask_n         = mask_r;
        ch_n           = ch_r;
        cnt_n          = cnt_r;
        busy_n         = busy_r;
        done_n         = 1'b0;
        sample_valid_n = 1'b0;
        sample_ch_n    = sample_ch_r;
        sample_data_n  = sample_data_r;
        scan_result_n  = scan_result_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (ch_mask != 4'b0000) begin
                        mask_n  = ch_mask;
                        busy_n  = 1'b1;
                        ch_n    = first_s[1:0];
                        cnt_n   = CNT_LOAD;
                        state_n = ST_DWELL;
                    end else begin
                        // Empty scan: report completion without ever going busy.
                        done_n  = 1'b1;
                        state_n = ST_FINISH;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_DWELL: begin
                if (cnt_r == 4'd0) begin
                    scan_result_n[ch_r] = y;
                    sample_data_n       = y;
                    sample_ch_n         = ch_r;
                    sample_valid_n      = 1'b1;
                    if (next_s[2]) begin
                        ch_n  = next_s[1:0];
                        cnt_n = CNT_LOAD;
                    end else begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = ST_FINISH;
                    end
                end else begin
                    cnt_n = cnt_r - 4'd1;
                end
            end
            ST_FINISH: begin
                state_n = ST_IDLE;
            end
            default: begin
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            mask_r         <= 4'b0000;
            ch_r           <= 2'b00;
            cnt_r          <= 4'd0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            sample_valid_r <= 1'b0;
            sample_ch_r    <= 2'b00;
            sample_data_r  <= 1'b0;
            scan_result_r  <= 4'b0000;
        end else begin
            state_r        <= state_n;
            mask_r         <= mask_n;
            ch_r           <= ch_n;
            cnt_r          <= cnt_n;
            busy_r         <= busy_n;
            done_r         <= done_n;
            sample_valid_r <= sample_valid_n;
            sample_ch_r    <= sample_ch_n;
            sample_data_r  <= sample_data_n;
            scan_result_r  <= scan_result_n;
        end
    end

    // The select lines come straight from the channel register, so they hold in IDLE.
    assign sel1         = ch_r[0];
    assign sel2         = ch_r[1];
    assign busy         = busy_r;
    assign done         = done_r;
    assign sample_valid = sample_valid_r;
    assign sample_ch    = sample_ch_r;
    assign sample_data  = sample_data_r;
    assign scan_result  = scan_result_r;

endmodule
